// File: rtl/uart8_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, start-edge detect, mid-bit sampling,
// registered one-cycle valid/err strobes. A held-low line is waited out in BREAK.
module uart8_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out,
  output logic       valid,
  output logic       err,
  output logic       busy
);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_out, w_out_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_err, w_err_nxt;
  logic          r_busy;
  logic          r_s1, r_rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b1;
      r_rx_s  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1    <= rx;
      r_rx_s  <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_out_nxt   = r_out;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt = '0;
          // Line back high at the start-bit centre: treat as a glitch
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_bit] = r_rx_s;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == C_FULL) begin
          w_cnt_nxt = '0;
          // Leave at the stop-bit centre so a back-to-back start edge is caught
          if (r_rx_s) begin
            w_out_nxt   = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (r_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign err   = r_err;
  assign busy  = r_busy;
endmodule

// File: tb/tb_uart8_receiver.sv
// Directed + randomized bench for uart8_receiver; expected outputs come from a
// frame-level model that scans the logged rx waveform using bit-period arithmetic.
module tb_uart8_receiver;
  localparam int CPB = 8;
  localparam int HB  = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n, rx;
  logic [7:0] out;
  logic       valid, err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  bit          rxlog[$];
  bit          rstlog[$];
  logic [10:0] obs[$];     // {valid, err, busy, out} after each rising edge

  bit          e_valid[];
  bit          e_err[];
  bit          e_busy[];
  logic [7:0]  e_byte[];

  uart8_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .out(out), .valid(valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rxlog.push_back(rx);
    rstlog.push_back(rst_n);
  end

  always @(negedge clk) obs.push_back({valid, err, busy, out});

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic b, input int nbits);
    rx = b;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_bits);
    send_bits(1'b0, 1);
    for (int k = 0; k < 8; k++) send_bits(b[k], 1);
    send_bits(1'b1, stop_bits);
  endtask

  // Stop bit held low; leaves the line low on return.
  task automatic send_bad_stop(input logic [7:0] b, input int low_bits);
    send_bits(1'b0, 1);
    for (int k = 0; k < 8; k++) send_bits(b[k], 1);
    send_bits(1'b0, low_bits);
  endtask

  function automatic bit rxat(input int i);
    return (i < rxlog.size()) ? rxlog[i] : 1'b1;
  endfunction

  task automatic mark_busy(input int a, input int b, input int r);
    for (int i = a; i < b && i < r && i < e_busy.size(); i++) e_busy[i] = 1'b1;
  endtask

  // Edge u sees the line as it was at edge u-2 (two-flop synchronizer).
  // Frames are found at rx index e0; centre of bit n sits at e0 + HB + n*CPB.
  task automatic model_segment(input int p0, input int r);
    int p, e0, s, j;
    logic [7:0] b;
    p = p0;
    while (1) begin
      while (p < rxlog.size() && rxat(p)) p++;
      e0 = p;
      if (e0 + 2 >= r) return;
      if (rxat(e0 + HB)) begin
        mark_busy(e0 + 2, e0 + 2 + HB, r);
        p = e0 + 1 + HB;
        continue;
      end
      for (int k = 0; k < 8; k++) b[k] = rxat(e0 + HB + (k + 1) * CPB);
      s = e0 + 2 + HB + 9 * CPB;
      if (rxat(s - 2)) begin
        mark_busy(e0 + 2, s, r);
        if (s < r) begin
          e_valid[s] = 1'b1;
          e_byte[s]  = b;
        end
        p = s - 1;
      end else begin
        j = s - 1;
        while (j < rxlog.size() && !rxat(j)) j++;
        mark_busy(e0 + 2, j + 2, r);
        if (s < r) e_err[s] = 1'b1;
        p = j + 1;
      end
    end
  endtask

  task automatic run_model();
    int n, t, se;
    n = rxlog.size();
    e_valid = new[n];
    e_err   = new[n];
    e_busy  = new[n];
    e_byte  = new[n];
    t = 0;
    while (t < n) begin
      if (!rstlog[t]) begin
        t++;
        continue;
      end
      se = t;
      while (se < n && rstlog[se]) se++;
      model_segment(t, se);
      t = se;
    end
  endtask

  initial begin
    int e0a, e0b, lim, kind;
    logic [7:0] rb, o;

    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out",   16'(out),   16'h00);
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_err",   16'(err),   16'h0);
    check("rst_busy",  16'(busy),  16'h0);
    rst_n = 1'b1;
    idle(6);

    e0a = rxlog.size();
    send_frame(8'hA5, 1);
    idle(10);
    check("a5_out", 16'(out), 16'hA5);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(12);
    check("glitch_out",  16'(out),  16'hA5);
    check("glitch_busy", 16'(busy), 16'h0);

    send_frame(8'h3C, 1);
    idle(5);
    check("3c_out", 16'(out), 16'h3C);

    send_bad_stop(8'h96, 20);
    check("break_busy", 16'(busy), 16'h1);
    check("break_out",  16'(out),  16'h3C);
    idle(10);
    check("break_exit", 16'(busy), 16'h0);

    send_frame(8'h81, 1);
    idle(4);
    check("81_out", 16'(out), 16'h81);

    e0b = rxlog.size();
    send_frame(8'h00, 1);
    send_frame(8'hFF, 1);
    idle(6);
    check("b2b_out", 16'(out), 16'hFF);

    // 0x5A, LSB first: 0,1,0 then reset mid-byte
    send_bits(1'b0, 1);
    send_bits(1'b0, 1);
    send_bits(1'b1, 1);
    send_bits(1'b0, 1);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_out",   16'(out),   16'h00);
    check("mid_rst_busy",  16'(busy),  16'h0);
    check("mid_rst_valid", 16'(valid), 16'h0);
    check("mid_rst_err",   16'(err),   16'h0);
    rst_n = 1'b1;
    idle(6);
    send_frame(8'hC3, 1);
    idle(4);
    check("c3_out", 16'(out), 16'hC3);

    for (int r = 0; r < 10; r++) begin
      kind = $urandom_range(0, 5);
      rb   = 8'($urandom);
      if (kind <= 3) begin
        send_frame(rb, $urandom_range(1, 2));
        idle($urandom_range(0, 12));
      end else if (kind == 4) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        idle(10);
      end else begin
        send_bad_stop(rb, $urandom_range(1, 3));
        idle($urandom_range(1, 12));
      end
    end
    idle(30);

    run_model();
    lim = ((obs.size() < rxlog.size()) ? obs.size() : rxlog.size()) - 1;
    o = 8'h00;
    for (int i = 0; i < lim; i++) begin
      if (!rstlog[i])     o = 8'h00;
      else if (e_valid[i]) o = e_byte[i];
      check($sformatf("cyc%0d", i), 16'(obs[i]), 16'({e_valid[i], e_err[i], e_busy[i], o}));
    end

    check("a5_lat",     16'(obs[e0a + 78][10]),  16'h1);
    check("a5_pre",     16'(obs[e0a + 77][10]),  16'h0);
    check("a5_post",    16'(obs[e0a + 79][10]),  16'h0);
    check("a5_byte",    16'(obs[e0a + 78][7:0]), 16'hA5);
    check("a5_busy_e2", 16'(obs[e0a + 2][8]),    16'h1);
    check("a5_busy_e1", 16'(obs[e0a + 1][8]),    16'h0);
    check("b2b_v0",     16'(obs[e0b + 78][10]),  16'h1);
    check("b2b_b0",     16'(obs[e0b + 78][7:0]), 16'h00);
    check("b2b_v1",     16'(obs[e0b + 158][10]), 16'h1);
    check("b2b_b1",     16'(obs[e0b + 158][7:0]), 16'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
